// File: rtl/ram256x16_access_master.sv
// Burst initiator for a 256x16 single-port RAM: streams write beats into the RAM and
// streams read beats out through a two-entry output buffer, all with valid/ready handshakes.
module ram256x16_access_master #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int OBUF_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_clk_en_o,
   output logic              ram_wr_en_o,
   output logic [DATA_W-1:0] ram_wr_data_o,
   input  logic [DATA_W-1:0] ram_rd_data_i
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [2:0]        DEPTH    = 3'(OBUF_DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                ram_clk_en_q, ram_clk_en_d;
   logic                ram_wr_en_q, ram_wr_en_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;
   logic                strb_last_q, strb_last_d;

   logic                rd_vld_q, rd_last_q;
   logic [DATA_W-1:0]   buf_data_q [OBUF_DEPTH];
   logic                buf_last_q [OBUF_DEPTH];
   logic                head_q;
   logic [1:0]          occ_q, occ_d;

   logic                rd_strobe, push, pop, wr_idx;
   logic [2:0]          pend;

   // A read is outstanding while its strobe is on the bus and again while its data is on
   // ram_rd_data_i; both must already own a buffer slot because future pops are unknown.
   assign rd_strobe = ram_clk_en_q & ~ram_wr_en_q;
   assign push      = rd_vld_q;
   assign pop       = rdata_valid & rdata_ready;
   assign pend      = {1'b0, occ_q} - {2'b00, pop} + {2'b00, rd_strobe} + {2'b00, rd_vld_q};
   assign occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
   assign wr_idx    = head_q ^ occ_q[0];

   assign cmd_ready     = (state_q == IDLE) & ~done_q;
   assign wdata_ready   = (state_q == WRITE);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign rdata_valid   = (occ_q != 2'd0);
   assign rdata         = buf_data_q[head_q];
   assign rdata_last    = rdata_valid & buf_last_q[head_q];
   assign ram_addr_o    = ram_addr_q;
   assign ram_clk_en_o  = ram_clk_en_q;
   assign ram_wr_en_o   = ram_wr_en_q;
   assign ram_wr_data_o = ram_wr_data_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      ram_clk_en_d  = 1'b0;
      ram_wr_en_d   = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      strb_last_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr;
               cnt_d   = {1'b0, cmd_len} + CNT_ONE;
               state_d = cmd_write ? WRITE : READ;
            end
         end
         WRITE: begin
            if (wdata_valid) begin
               ram_clk_en_d  = 1'b1;
               ram_wr_en_d   = 1'b1;
               ram_addr_d    = addr_q;
               ram_wr_data_d = wdata;
               addr_d        = addr_q + ADDR_ONE;
               cnt_d         = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (pend < DEPTH) begin
               ram_clk_en_d = 1'b1;
               ram_addr_d   = addr_q;
               strb_last_d  = (cnt_q == CNT_ONE);
               addr_d       = addr_q + ADDR_ONE;
               cnt_d        = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pend == 3'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         ram_clk_en_q  <= 1'b0;
         ram_wr_en_q   <= 1'b0;
         ram_addr_q    <= '0;
         ram_wr_data_q <= '0;
         strb_last_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         done_q        <= done_d;
         ram_clk_en_q  <= ram_clk_en_d;
         ram_wr_en_q   <= ram_wr_en_d;
         ram_addr_q    <= ram_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         strb_last_q   <= strb_last_d;
      end
   end

   // Returned words land in the buffer one cycle after their strobe left the bus.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            buf_data_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
         head_q    <= 1'b0;
         occ_q     <= 2'd0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
      end else begin
         rd_vld_q  <= rd_strobe;
         rd_last_q <= strb_last_q;
         if (push) begin
            buf_data_q[wr_idx] <= ram_rd_data_i;
            buf_last_q[wr_idx] <= rd_last_q;
         end
         head_q <= head_q ^ pop;
         occ_q  <= occ_d;
      end
   end
endmodule
